// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and the index width needed to walk WIDTH/4 nibbles.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-nibble datapath would still need a 1-bit index register.
  function automatic int idx_w(input int width);
    return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder cell; every carry is a flat function of g/p/cin.
module carrylookahead_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g, p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/subtract sequenced one nibble per clock through a single CLA cell,
// with the inter-nibble carry held in carry_reg.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_w(WIDTH);

  state_t state, state_nx;

  logic [N-1:0][NIBBLE_W-1:0] a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0]           idx;
  logic                       carry_reg, a_msb, b_msb, cout_reg, ovf_reg;
  logic [WIDTH-1:0]           b_eff;
  logic [NIBBLE_W-1:0]        nib_a, nib_b, nib_s;
  logic                       nib_c, last;

  assign b_eff = sub ? ~b : b;
  assign nib_a = a_reg[idx];
  assign nib_b = b_reg[idx];
  assign last  = (idx == IDX_W'(N - 1));

  carrylookahead_adder u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_reg),
    .sum  (nib_s),
    .cout (nib_c)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operands stay parallel in a_reg/b_reg so they remain visible while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg     <= a;
          b_reg     <= b_eff;
          carry_reg <= sub | cin;
          idx       <= '0;
          a_msb     <= a[WIDTH-1];
          b_msb     <= b_eff[WIDTH-1];
        end
        RUN: begin
          sum_reg[idx] <= nib_s;
          carry_reg    <= nib_c;
          idx          <= idx + IDX_W'(1);
          if (last) begin
            cout_reg <= nib_c;
            ovf_reg  <= (a_msb == b_msb) && (nib_s[NIBBLE_W-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder/subtractor that feeds one 4-bit slice per clock through a single 4-bit carry-lookahead adder cell, registering the carry between slices. It is the sequencing stage directly upstream of the 4-bit CLA cell. It lets datapaths wider than 4 bits reuse one cell at the cost of WIDTH/4 cycles of latency. Operands are captured on a start pulse; a one-cycle done pulse reports the result.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only while busy=0.
- sub  input  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced to 1, cin ignored); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; captured with start.
- busy  output  1  high from the cycle after start is accepted until done completes.
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry-out; on subtract, 1 means no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow of the full-width result.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN when start=1. Capture a into a_reg, capture (sub ? ~b : b) into b_reg, and set carry_reg to (sub ? 1 : cin). Clear idx. Store a[WIDTH-1] and (sub ? ~b : b)[WIDTH-1] for the overflow calculation.
  - In RUN, each cycle sends nibble idx of a_reg and b_reg, plus carry_reg, to the CLA cell. The 4-bit result is written into sum[4*idx+3:4*idx], carry_reg takes the cell's cout, and idx increments.
  - RUN→DONE on the edge that writes nibble WIDTH/4-1.
  - DONE→IDLE unconditionally after one cycle.
- busy=1 in RUN and DONE. done=1 only in DONE.
- cout equals carry_reg at DONE.
- ovf = (stored A msb == stored effective-B msb) && (sum[WIDTH-1] != stored A msb). It is registered on the same edge as the last nibble.
- A start seen while busy=1 is ignored entirely; captured operands do not change.
- start in the DONE cycle is ignored. A new start is accepted in IDLE the following cycle at the earliest.
- sum, cout and ovf keep their values through IDLE. sum nibbles update progressively during RUN; consumers use them only at or after done.
- All arithmetic is unsigned modulo 2^WIDTH. The carry out of the top nibble goes only to cout.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, idx=0, carry_reg=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and outputs return to their reset values.
- start is sampled at edge T0. busy=1 from T0. Nibbles are written at edges T1…T(N), where N=WIDTH/4.
- done=1 during the cycle following edge T(N). With WIDTH=16, done is high 4 cycles after the start edge.
- busy=0 after edge T(N+1). Minimum issue interval is N+2 cycles.
- The CLA path is purely combinational within one cycle: a_reg/b_reg nibble and carry_reg go in, and the result registers at the next edge.

## Structure
- Shared header nibble_serial_defs: NIBBLE_W=4, the 2-bit state encodings (IDLE=0, RUN=1, DONE=2) and the idx width as clog2(WIDTH/4).
- One sub-module: a single instance of carrylookahead_adder (4-bit a/b, cin, sum, cout). All 4-bit arithmetic goes through it; no behavioural '+' for nibble sums.
- idx drives nibble selection through a mux on a_reg/b_reg. Do not use a shift register, so that held operands remain inspectable.

## Test plan
- Add 0x1234+0x4321, cin=0: done exactly 4 cycles after the start edge; sum=0x5555, cout=0, ovf=0. busy is high for 5 cycles.
- Add 0xFFFF+0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Ripple through all four nibbles is checked.
- Add 0x7FFF+0x0000, cin=1: sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005-0x0007 (sub=1, cin=1 ignored): sum=0xFFFE, cout=0, ovf=0. Then subtract 0x8000-0x0001: sum=0x7FFF, cout=1, ovf=1.
- Start 0x1111+0x2222, then pulse start with 0xFFFF+0xFFFF at T2 and again during DONE: both extra starts are ignored, and the result is 0x3333 with a single done pulse.
- Start 0xAAAA+0x5555, assert rst between T2 and T3: all outputs go to 0 asynchronously with no done. After release, 0x0001+0x0001 gives 0x0002.
